sle_bank_ctrl: RTL and testbench
================================

Name: sle_bank_ctrl

Overview:
Command-driven sequencer that owns a bank of NUM_CELLS SLE cells, which share their data and sync-load lines and each have their own enable. It turns single-beat commands (write, sync load, broadcast clear/set, read, latch-mode config) into correctly ordered EN/SLn/SD/D/LAT cycles on the bank. Read results return over a valid/ready response channel. Cell ALn and ADn are tied inactive outside this block (ALn=1); the controller never drives the async-load path.

Parameters:
NUM_CELLS, 8, number of SLE cells in the bank (2..32)
ADDR_W, 3, cell address width; must satisfy 2**ADDR_W >= NUM_CELLS
LAT_HOLD, 2, DRIVE duration in cycles while latch mode is on (>=1)

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  reset, synchronous, active-low
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_op  input  3  opcode
cmd_addr  input  ADDR_W  target cell
cmd_data  input  1  write / SD / LAT value
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed
rsp_data  output  1  read data
rsp_err  output  1  error flag for bad opcode or bad address
busy  output  1  state != IDLE
sle_en  output  NUM_CELLS  per-cell EN
sle_d  output  1  shared D
sle_sln  output  1  shared SLn (active-low sync load)
sle_sd  output  1  shared SD
sle_lat  output  1  shared LAT (1 = latch mode)
sle_q  input  NUM_CELLS  cell Q outputs

Behaviour:
- Reset: RSTn low at a rising edge forces the following values from the next cycle.
  - state=IDLE, sle_en=0, sle_d=0, sle_sln=1, sle_sd=0, sle_lat=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - cmd_ready = (state==IDLE) && RSTn.
  - A reset mid-operation drops any in-flight drive or pending response. Cell contents are untouched.
- All bank outputs are registered. FSM states are IDLE, DRIVE, SETTLE, SAMPLE, RESP.
- Opcodes:
  - 0 NOP: accepted; no effect; no response.
  - 1 WRITE: sle_en=onehot(addr), sle_sln=1, sle_d=cmd_data.
  - 2 SLOAD: sle_en=onehot(addr), sle_sln=0, sle_sd=cmd_data.
  - 3 CLR_ALL: sle_en=all ones, sle_sln=0, sle_sd=0. Address ignored.
  - 4 SET_ALL: same as CLR_ALL with sle_sd=1.
  - 5 READ: returns sle_q[addr].
  - 6 CFG_LAT: sle_lat <= cmd_data.
  - 7: reserved.
- Drive ops (1-4), accepted at edge k:
  - DRIVE starts at cycle k+1 and lasts 1 cycle, or LAT_HOLD cycles if sle_lat=1 (down-counter).
  - Then SETTLE for 1 cycle: sle_en=0, sle_sln=1, sle_d/sle_sd held.
  - Then IDLE. No response is generated.
- READ, accepted at edge k:
  - SAMPLE at cycle k+1, with sle_en=0.
  - rsp_data <= sle_q[addr] at edge k+2; rsp_valid=1 from cycle k+2 (RESP).
  - Held until rsp_valid && rsp_ready at an edge, then IDLE next cycle.
- CFG_LAT, accepted at edge k: sle_lat updates at edge k+1, with state=SETTLE for 1 cycle, then IDLE. LAT therefore never changes while any sle_en bit is high.
- Errors:
  - Conditions: opcode 7; or addr >= NUM_CELLS for WRITE, SLOAD or READ.
  - No bank drive; go to RESP with rsp_err=1, rsp_data=0.
  - Same handshake as READ; rsp_valid is asserted at edge k+1.
- Invariants:
  - sle_en != 0 only in DRIVE.
  - popcount(sle_en) <= 1 except for CLR_ALL/SET_ALL.
  - sle_sln=0 only in DRIVE.
  - cmd_ready=0 in every state except IDLE, including while RESP is stalled on rsp_ready=0.

Decomposition:
- Package sle_ctrl_pkg holds:
  - opcode localparams: OP_NOP..OP_RSVD, OP_W=3;
  - FSM state encoding.
- One sub-module, sle_addr_decode: addr -> onehot sle_en vector plus in-range flag, parameterised by NUM_CELLS/ADDR_W.

Test Plan:
1. Reset with cmd_valid high -> all outputs at reset values, cmd_ready=0 while RSTn=0; cmd_ready=1 on the first cycle after RSTn rises.
2. WRITE addr=3 data=1 with lat=0 -> sle_en=8'b0000_1000, sle_sln=1, sle_d=1 for exactly 1 cycle, then SETTLE. Follow with READ addr=3 -> rsp_valid 2 cycles after accept, rsp_data=1, rsp_err=0.
3. SLOAD addr=5 data=0, then SET_ALL, then CLR_ALL back-to-back -> each accepted 3 cycles apart; sle_sln=0 only during DRIVE; sle_en=8'hFF for SET/CLR; subsequent READs of cells 0-7 all return 0.
4. CFG_LAT data=1, then WRITE addr=0 data=1 -> sle_lat=1 before DRIVE; sle_en[0] high for LAT_HOLD=2 cycles; sle_lat stable throughout.
5. READ addr=6 with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data held, cmd_ready=0. A new cmd_valid is not accepted until the cycle after rsp_ready=1.
6. Opcode 7, and WRITE with NUM_CELLS=6 and addr=7 -> rsp_err=1, rsp_data=0, sle_en stays 0. Also: RSTn low during DRIVE -> sle_en=0 and state=IDLE next cycle.

Source files
------------

// File: rtl/sle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sle_ctrl_pkg
// Shared definitions for the SLE bank controller:
//   - command opcode encodings (OP_W bits wide)
//   - controller FSM state encoding
// No ports; imported by sle_addr_decode and sle_bank_ctrl.
// -----------------------------------------------------------------------------
package sle_ctrl_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
  localparam logic [OP_W-1:0] OP_WRITE   = 3'd1;
  localparam logic [OP_W-1:0] OP_SLOAD   = 3'd2;
  localparam logic [OP_W-1:0] OP_CLR_ALL = 3'd3;
  localparam logic [OP_W-1:0] OP_SET_ALL = 3'd4;
  localparam logic [OP_W-1:0] OP_READ    = 3'd5;
  localparam logic [OP_W-1:0] OP_CFG_LAT = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/sle_addr_decode.sv
// -----------------------------------------------------------------------------
// sle_addr_decode
// Turns a cell address into a one-hot enable vector and flags whether the
// address names an existing cell.
// Ports:
//   i_addr     in   ADDR_W     cell address
//   o_onehot   out  NUM_CELLS  one-hot select (all zero when out of range)
//   o_in_range out  1          i_addr < NUM_CELLS
// -----------------------------------------------------------------------------
module sle_addr_decode
  import sle_ctrl_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int ADDR_W    = 3
) (
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [NUM_CELLS-1:0] o_onehot,
  output logic                 o_in_range
);

  // One extra bit so NUM_CELLS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] LP_LIMIT = (ADDR_W+1)'(NUM_CELLS);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (i_addr == ADDR_W'(i)) begin
        o_onehot[i] = 1'b1;
      end
    end
    o_in_range = ({1'b0, i_addr} < LP_LIMIT);
  end

endmodule

// File: rtl/sle_bank_ctrl.sv
// -----------------------------------------------------------------------------
// sle_bank_ctrl
// Command-driven sequencer for a bank of NUM_CELLS SLE cells sharing D, SLn,
// SD and LAT, each with its own EN. Single-beat commands become ordered
// EN/SLn/SD/D/LAT cycles; reads and errors return on a valid/ready channel.
// The async-load path (ALn/ADn) is never driven from here.
// Ports:
//   CLK, RSTn            clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_op/cmd_addr/cmd_data payload
//   rsp_valid/rsp_ready  response handshake; rsp_data read bit, rsp_err error
//   busy                 controller not idle
//   sle_en               per-cell enable (registered)
//   sle_d/sle_sln/sle_sd/sle_lat  shared bank controls (registered)
//   sle_q                cell outputs, sampled by READ
// -----------------------------------------------------------------------------
module sle_bank_ctrl
  import sle_ctrl_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int ADDR_W    = 3,
  parameter int LAT_HOLD  = 2
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic                 cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [NUM_CELLS-1:0] sle_en,
  output logic                 sle_d,
  output logic                 sle_sln,
  output logic                 sle_sd,
  output logic                 sle_lat,
  input  logic [NUM_CELLS-1:0] sle_q
);

  // DRIVE length is counted down from LAT_HOLD-1 in latch mode, 0 otherwise.
  localparam int CNT_W = (LAT_HOLD > 1) ? $clog2(LAT_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LAT_HOLD - 1);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_CELLS-1:0] r_sel, w_sel_nxt;
  logic [NUM_CELLS-1:0] r_en, w_en_nxt;
  logic                 r_d, w_d_nxt;
  logic                 r_sln, w_sln_nxt;
  logic                 r_sd, w_sd_nxt;
  logic                 r_lat, w_lat_nxt;
  logic                 r_rsp_valid, w_rsp_valid_nxt;
  logic                 r_rsp_data, w_rsp_data_nxt;
  logic                 r_rsp_err, w_rsp_err_nxt;

  logic [NUM_CELLS-1:0] w_onehot;
  logic                 w_in_range;
  logic                 w_bad;
  logic [CNT_W-1:0]     w_hold_load;
  logic                 w_q_bit;

  sle_addr_decode #(
    .NUM_CELLS (NUM_CELLS),
    .ADDR_W    (ADDR_W)
  ) u_decode (
    .i_addr     (cmd_addr),
    .o_onehot   (w_onehot),
    .o_in_range (w_in_range)
  );

  assign w_hold_load = r_lat ? HOLD_LOAD : '0;
  // The select latched at READ accept picks the cell bit during SAMPLE.
  assign w_q_bit     = |(sle_q & r_sel);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sel_nxt       = r_sel;
    w_en_nxt        = r_en;
    w_d_nxt         = r_d;
    w_sln_nxt       = r_sln;
    w_sd_nxt        = r_sd;
    w_lat_nxt       = r_lat;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_bad           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: w_bad = 1'b0;
            OP_WRITE: begin
              if (w_in_range) begin
                w_state_nxt = ST_DRIVE;
                w_en_nxt    = w_onehot;
                w_sln_nxt   = 1'b1;
                w_d_nxt     = cmd_data;
                w_cnt_nxt   = w_hold_load;
              end else begin
                w_bad = 1'b1;
              end
            end
            OP_SLOAD: begin
              if (w_in_range) begin
                w_state_nxt = ST_DRIVE;
                w_en_nxt    = w_onehot;
                w_sln_nxt   = 1'b0;
                w_sd_nxt    = cmd_data;
                w_cnt_nxt   = w_hold_load;
              end else begin
                w_bad = 1'b1;
              end
            end
            OP_CLR_ALL, OP_SET_ALL: begin
              w_state_nxt = ST_DRIVE;
              w_en_nxt    = '1;
              w_sln_nxt   = 1'b0;
              w_sd_nxt    = (cmd_op == OP_SET_ALL);
              w_cnt_nxt   = w_hold_load;
            end
            OP_READ: begin
              if (w_in_range) begin
                w_state_nxt = ST_SAMPLE;
                w_sel_nxt   = w_onehot;
              end else begin
                w_bad = 1'b1;
              end
            end
            OP_CFG_LAT: begin
              // LAT changes only here, while every EN bit is low.
              w_state_nxt = ST_SETTLE;
              w_lat_nxt   = cmd_data;
            end
            default: w_bad = 1'b1;
          endcase

          if (w_bad) begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_data_nxt  = 1'b0;
          end
        end
      end

      ST_DRIVE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_SETTLE;
          w_en_nxt    = '0;
          w_sln_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_SETTLE: w_state_nxt = ST_IDLE;

      ST_SAMPLE: begin
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = w_q_bit;
        w_rsp_err_nxt   = 1'b0;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_en        <= '0;
      r_d         <= 1'b0;
      r_sln       <= 1'b1;
      r_sd        <= 1'b0;
      r_lat       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_en        <= w_en_nxt;
      r_d         <= w_d_nxt;
      r_sln       <= w_sln_nxt;
      r_sd        <= w_sd_nxt;
      r_lat       <= w_lat_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
    // Counter and read select are always loaded before use.
    r_cnt <= w_cnt_nxt;
    r_sel <= w_sel_nxt;
  end

  assign cmd_ready = (r_state == ST_IDLE) && RSTn;
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign sle_en    = r_en;
  assign sle_d     = r_d;
  assign sle_sln   = r_sln;
  assign sle_sd    = r_sd;
  assign sle_lat   = r_lat;

endmodule

// File: tb/tb_sle_bank_ctrl.sv
module tb_sle_bank_ctrl;
  import sle_ctrl_pkg::*;

  localparam int NC = 8;
  localparam int AW = 3;
  localparam int LH = 2;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  logic          cmd_valid, cmd_valid6, cmd_ready, cmd_ready6;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic          cmd_data;
  logic          rsp_ready;
  logic          rsp_valid, rsp_data, rsp_err, busy;
  logic [NC-1:0] sle_en;
  logic          sle_d, sle_sln, sle_sd, sle_lat;
  logic          rsp_valid6, rsp_data6, rsp_err6, busy6;
  logic [5:0]    sle_en6;
  logic          sle_d6, sle_sln6, sle_sd6, sle_lat6;
  logic [5:0]    sle_q6 = 6'b101010;

  // Behavioural cell bank: an enabled cell loads SD when SLn is low, else D.
  logic [NC-1:0] bank_q = '0;
  always @(posedge CLK)
    for (int i = 0; i < NC; i++)
      if (sle_en[i]) bank_q[i] <= sle_sln ? sle_d : sle_sd;

  sle_bank_ctrl #(.NUM_CELLS(NC), .ADDR_W(AW), .LAT_HOLD(LH)) dut (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .sle_en(sle_en), .sle_d(sle_d),
    .sle_sln(sle_sln), .sle_sd(sle_sd), .sle_lat(sle_lat), .sle_q(bank_q));

  sle_bank_ctrl #(.NUM_CELLS(6), .ADDR_W(AW), .LAT_HOLD(LH)) dut6 (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready), .rsp_data(rsp_data6),
    .rsp_err(rsp_err6), .busy(busy6), .sle_en(sle_en6), .sle_d(sle_d6),
    .sle_sln(sle_sln6), .sle_sd(sle_sd6), .sle_lat(sle_lat6), .sle_q(sle_q6));

  // Command-level reference: cell contents and latch mode.
  bit ref_mem [NC];
  bit ref_lat;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_on = 0;
  logic prev_lat = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Bank-level rules that must hold on every cycle.
  always @(negedge CLK) begin
    if (mon_on) begin
      n_vec++;
      if ((sle_sln === 1'b0 && sle_en == '0) || (sle_en != '0 && !busy) ||
          ($countones(sle_en) > 1 && sle_en !== '1) ||
          (sle_en != '0 && sle_lat !== prev_lat) || (sle_en != '0 && cmd_ready)) begin
        n_err++;
        $display("FAIL bank_rules t=%0t: en=%b sln=%b lat=%b prev_lat=%b busy=%b rdy=%b",
                 $time, sle_en, sle_sln, sle_lat, prev_lat, busy, cmd_ready);
      end
      prev_lat = sle_lat;
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Presents one command and returns one step after the accepting edge.
  task automatic issue(input logic [2:0] op, input int a, input logic d,
                       input bit to6, output bit acc);
    cmd_op = op; cmd_addr = a[AW-1:0]; cmd_data = d;
    if (to6) cmd_valid6 = 1'b1; else cmd_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (to6 ? cmd_ready6 : cmd_ready) acc = 1;
      step();
      if (acc) break;
    end
    cmd_valid = 1'b0; cmd_valid6 = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin ok = 1; break; end
      step();
    end
  endtask

  // Waits for a response on the main DUT, then consumes it after a random stall.
  task automatic get_rsp(output logic dat, output logic err, output bit got);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) begin got = 1; break; end
      step();
    end
    dat = rsp_data; err = rsp_err;
    repeat ($urandom_range(0, 2)) step();
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 3; cmd_data = 1'b1;
    repeat (3) step();
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b want 0", cmd_ready);
    end
    n_vec++;
    if ({busy, rsp_valid, rsp_data, rsp_err, sle_sln, sle_d, sle_sd, sle_lat} !== 8'b0000_1000) begin
      n_err++;
      $display("FAIL reset_outs: got busy/rv/rd/re/sln/d/sd/lat=%b want 00001000",
               {busy, rsp_valid, rsp_data, rsp_err, sle_sln, sle_d, sle_sd, sle_lat});
    end
    n_vec++;
    if (sle_en !== '0) begin n_err++; $display("FAIL reset_en: got %b want 0", sle_en); end
    cmd_valid = 1'b0; RSTn = 1'b1; #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
    mon_on = 1;
  endtask

  task automatic test_write_read();
    bit acc, ok;
    issue(OP_WRITE, 3, 1'b1, 0, acc);
    n_vec++;
    if (!acc || sle_en !== 8'b0000_1000 || sle_sln !== 1'b1 || sle_d !== 1'b1 || !busy) begin
      n_err++; $display("FAIL write_drive: acc=%b en=%b sln=%b d=%b want en=00001000 sln=1 d=1",
                        acc, sle_en, sle_sln, sle_d);
    end
    step();
    n_vec++;
    if (sle_en !== '0 || sle_sln !== 1'b1 || sle_d !== 1'b1 || !busy) begin
      n_err++; $display("FAIL write_settle: en=%b sln=%b d=%b busy=%b want 0/1/1/1",
                        sle_en, sle_sln, sle_d, busy);
    end
    wait_idle(ok);
    ref_mem[3] = 1;
    issue(OP_READ, 3, 1'b0, 0, acc);
    n_vec++;
    if (!acc || rsp_valid !== 1'b0 || sle_en !== '0) begin
      n_err++; $display("FAIL read_sample: acc=%b rv=%b en=%b want 1/0/0", acc, rsp_valid, sle_en);
    end
    step();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[3] || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL read_resp: rv=%b rd=%b re=%b want 1/%b/0",
                        rsp_valid, rsp_data, rsp_err, ref_mem[3]);
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL read_done: rv=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, ok, got;
    int c0, c1, c2;
    logic dat, err;
    issue(OP_SLOAD, 5, 1'b0, 0, acc); c0 = cyc;
    n_vec++;
    if (!acc || sle_en !== 8'b0010_0000 || sle_sln !== 1'b0 || sle_sd !== 1'b0) begin
      n_err++; $display("FAIL sload_drive: en=%b sln=%b sd=%b want 00100000/0/0", sle_en, sle_sln, sle_sd);
    end
    issue(OP_SET_ALL, 0, 1'b0, 0, acc); c1 = cyc;
    n_vec++;
    if (!acc || sle_en !== 8'hFF || sle_sln !== 1'b0 || sle_sd !== 1'b1 || c1 - c0 != 3) begin
      n_err++; $display("FAIL set_all: en=%h sln=%b sd=%b gap=%0d want ff/0/1/3",
                        sle_en, sle_sln, sle_sd, c1 - c0);
    end
    issue(OP_CLR_ALL, 2, 1'b1, 0, acc); c2 = cyc;
    n_vec++;
    if (!acc || sle_en !== 8'hFF || sle_sln !== 1'b0 || sle_sd !== 1'b0 || c2 - c1 != 3) begin
      n_err++; $display("FAIL clr_all: en=%h sln=%b sd=%b gap=%0d want ff/0/0/3",
                        sle_en, sle_sln, sle_sd, c2 - c1);
    end
    wait_idle(ok);
    for (int i = 0; i < NC; i++) ref_mem[i] = 0;
    for (int i = 0; i < NC; i++) begin
      issue(OP_READ, i, 1'b0, 0, acc);
      get_rsp(dat, err, got);
      n_vec++;
      if (!acc || !got || dat !== ref_mem[i] || err !== 1'b0) begin
        n_err++; $display("FAIL read_after_clr[%0d]: got=%b data=%b err=%b want 1/%b/0",
                          i, got, dat, err, ref_mem[i]);
      end
    end
  endtask

  task automatic test_latch();
    bit acc, ok;
    int cnt;
    issue(OP_CFG_LAT, 0, 1'b1, 0, acc);
    n_vec++;
    if (!acc || sle_lat !== 1'b1 || busy !== 1'b1 || sle_en !== '0) begin
      n_err++; $display("FAIL cfg_lat: lat=%b busy=%b en=%b want 1/1/0", sle_lat, busy, sle_en);
    end
    ref_lat = 1;
    wait_idle(ok);
    issue(OP_WRITE, 0, 1'b1, 0, acc);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (sle_en == 8'b0000_0001 && sle_lat === 1'b1) cnt++;
      step();
    end
    n_vec++;
    if (!acc || cnt != LH) begin
      n_err++; $display("FAIL latch_hold: en cycles=%0d want %0d", cnt, LH);
    end
    ref_mem[0] = 1;
    wait_idle(ok);
    issue(OP_CFG_LAT, 0, 1'b0, 0, acc);
    ref_lat = 0;
    wait_idle(ok);
  endtask

  task automatic test_stall();
    bit acc, ok;
    issue(OP_WRITE, 6, 1'b1, 0, acc);
    wait_idle(ok);
    ref_mem[6] = 1;
    issue(OP_READ, 6, 1'b0, 0, acc);
    step();
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 2; cmd_data = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[6] || cmd_ready !== 1'b0 || sle_en !== '0) begin
        n_err++; $display("FAIL stall_hold[%0d]: rv=%b rd=%b rdy=%b en=%b want 1/%b/0/0",
                          i, rsp_valid, rsp_data, cmd_ready, sle_en, ref_mem[6]);
      end
      step();
    end
    rsp_ready = 1'b1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_hs: got %b want 0", cmd_ready); end
    step();
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || sle_en !== '0) begin
      n_err++; $display("FAIL stall_release: rv=%b rdy=%b en=%b want 0/1/0", rsp_valid, cmd_ready, sle_en);
    end
    step();
    cmd_valid = 1'b0;
    n_vec++;
    if (sle_en !== 8'b0000_0100) begin
      n_err++; $display("FAIL stall_next_cmd: en=%b want 00000100", sle_en);
    end
    ref_mem[2] = 1;
    wait_idle(ok);
  endtask

  task automatic test_errors();
    bit acc;
    issue(OP_RSVD, 2, 1'b1, 0, acc);
    n_vec++;
    if (!acc || {rsp_valid, rsp_err, rsp_data} !== 3'b110 || sle_en !== '0) begin
      n_err++; $display("FAIL err_rsvd: acc=%b rv/re/rd=%b en=%b want 110/0",
                        acc, {rsp_valid, rsp_err, rsp_data}, sle_en);
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL err_rsvd_done: rv=%b want 0", rsp_valid); end

    issue(OP_WRITE, 7, 1'b1, 1, acc);
    n_vec++;
    if (!acc || {rsp_valid6, rsp_err6, rsp_data6} !== 3'b110 || sle_en6 !== '0) begin
      n_err++; $display("FAIL err_addr_write: acc=%b rv/re/rd=%b en=%b want 110/0",
                        acc, {rsp_valid6, rsp_err6, rsp_data6}, sle_en6);
    end
    step();
    n_vec++;
    if (sle_en6 !== '0 || rsp_valid6 !== 1'b1) begin
      n_err++; $display("FAIL err_addr_hold: en=%b rv=%b want 0/1", sle_en6, rsp_valid6);
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    issue(OP_READ, 6, 1'b0, 1, acc);
    n_vec++;
    if (!acc || {rsp_valid6, rsp_err6, rsp_data6} !== 3'b110) begin
      n_err++; $display("FAIL err_addr_read: rv/re/rd=%b want 110", {rsp_valid6, rsp_err6, rsp_data6});
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    for (int a = 0; a < 6; a += 3) begin
      issue(OP_READ, a + 1, 1'b0, 1, acc);
      step();
      n_vec++;
      if (!acc || rsp_valid6 !== 1'b1 || rsp_err6 !== 1'b0 || rsp_data6 !== sle_q6[a+1]) begin
        n_err++; $display("FAIL read6[%0d]: rv=%b re=%b rd=%b want 1/0/%b",
                          a + 1, rsp_valid6, rsp_err6, rsp_data6, sle_q6[a+1]);
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_drive();
    bit acc, ok;
    issue(OP_CFG_LAT, 0, 1'b1, 0, acc);
    wait_idle(ok);
    issue(OP_WRITE, 4, ref_mem[4], 0, acc);
    n_vec++;
    if (!acc || sle_en !== 8'b0001_0000) begin
      n_err++; $display("FAIL mid_drive_en: en=%b want 00010000", sle_en);
    end
    RSTn = 1'b0;
    step();
    n_vec++;
    if (sle_en !== '0 || busy !== 1'b0 || sle_lat !== 1'b0 || sle_sln !== 1'b1) begin
      n_err++; $display("FAIL mid_drive_reset: en=%b busy=%b lat=%b sln=%b want 0/0/0/1",
                        sle_en, busy, sle_lat, sle_sln);
    end
    RSTn = 1'b1;
    ref_lat = 0;
    #1;
  endtask

  task automatic test_random();
    bit acc, ok, got, bad;
    logic [2:0] op;
    int a, cnt, exp_cnt;
    logic d, dat, err, exp_sln;
    logic [NC-1:0] exp_en;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, NC - 1);
      d  = 1'($urandom_range(0, 1));
      issue(op, a, d, 0, acc);
      n_vec++;
      if (!acc) begin n_err++; $display("FAIL rnd_accept[%0d]: op=%0d not accepted", n, op); end
      if (op >= OP_WRITE && op <= OP_SET_ALL) begin
        exp_en  = (op == OP_WRITE || op == OP_SLOAD) ? NC'(1) << a : '1;
        exp_sln = (op == OP_WRITE);
        exp_cnt = ref_lat ? LH : 1;
        cnt = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
          if (sle_en == '0) break;
          if (sle_en !== exp_en || sle_sln !== exp_sln) bad = 1;
          if (op == OP_WRITE && sle_d !== d) bad = 1;
          if (op == OP_SLOAD && sle_sd !== d) bad = 1;
          if (op == OP_SET_ALL && sle_sd !== 1'b1) bad = 1;
          if (op == OP_CLR_ALL && sle_sd !== 1'b0) bad = 1;
          cnt++; step();
        end
        n_vec++;
        if (bad || cnt != exp_cnt) begin
          n_err++; $display("FAIL rnd_drive[%0d]: op=%0d a=%0d cycles=%0d want %0d bad=%b",
                            n, op, a, cnt, exp_cnt, bad);
        end
        if (op == OP_CLR_ALL || op == OP_SET_ALL)
          for (int i = 0; i < NC; i++) ref_mem[i] = (op == OP_SET_ALL);
        else
          ref_mem[a] = d;
      end else if (op == OP_READ || op == OP_RSVD) begin
        get_rsp(dat, err, got);
        n_vec++;
        if (!got || (op == OP_READ  && (dat !== ref_mem[a] || err !== 1'b0)) ||
                    (op == OP_RSVD && (dat !== 1'b0 || err !== 1'b1))) begin
          n_err++; $display("FAIL rnd_rsp[%0d]: op=%0d a=%0d got=%b data=%b err=%b want data=%b",
                            n, op, a, got, dat, err, (op == OP_READ) ? ref_mem[a] : 1'b0);
        end
      end else if (op == OP_CFG_LAT) begin
        ref_lat = d;
        n_vec++;
        if (sle_lat !== d) begin n_err++; $display("FAIL rnd_lat[%0d]: lat=%b want %b", n, sle_lat, d); end
      end else begin
        n_vec++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
          n_err++; $display("FAIL rnd_nop[%0d]: busy=%b rv=%b want 0/0", n, busy, rsp_valid);
        end
      end
      wait_idle(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rnd_idle[%0d]: still busy after op=%0d", n, op); end
    end
  endtask

  initial begin
    RSTn = 1'b0; cmd_valid = 1'b0; cmd_valid6 = 1'b0; rsp_ready = 1'b0;
    cmd_op = OP_NOP; cmd_addr = '0; cmd_data = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_latch();
    test_stall();
    test_errors();
    test_reset_mid_drive();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
